// File: rtl/remote_cmd_tx.sv
// remote_cmd_tx: sends a 16-bit command as back-to-back 8N1 UART frames, high byte first
// Ports: clk, rst_n (async active-low) | cmd[15:0], snd_cmd (accepted only when idle)
//        TX (serial line, idle high), busy (accept..last stop bit), cmd_sent (sticky done)
// Option: CMD_TX_CHKSUM_EN appends a third frame carrying cmd[15:8]^cmd[7:0]
module remote_cmd_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
`ifdef CMD_TX_CHKSUM_EN
    localparam logic [1:0] CHK  = 2'd3;
`endif
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic [1:0]  state, next_state;
    logic [15:0] hold, baud_cnt;
    logic [3:0]  bit_cnt;
    logic [9:0]  shift;
    logic [7:0]  next_byte;
    logic        bit_end, frame_end;

    always_comb begin
        bit_end   = baud_cnt == BAUD_LAST;
        frame_end = bit_cnt == 4'd9;
`ifdef CMD_TX_CHKSUM_EN
        next_state = state == HIGH ? LOW : state == LOW ? CHK : IDLE;
        next_byte  = state == HIGH ? hold[7:0] : hold[15:8] ^ hold[7:0];
`else
        next_state = state == HIGH ? LOW : IDLE;
        next_byte  = hold[7:0];
`endif
    end

    // TX trails the shift register by one clock, so the start bit appears the edge after accept
    // and completion is flagged one clock after the FSM returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TX       <= 1'b1;
            busy     <= 1'b0;
            cmd_sent <= 1'b0;
            state    <= IDLE;
            hold     <= '0;
            shift    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            TX <= busy ? shift[0] : 1'b1;
            if (snd_cmd && !busy) begin
                hold     <= cmd;
                busy     <= 1'b1;
                cmd_sent <= 1'b0;
                state    <= HIGH;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                shift    <= {1'b1, cmd[15:8], 1'b0};
            end else if (state == IDLE) begin
                if (busy) begin
                    busy     <= 1'b0;
                    cmd_sent <= 1'b1;
                end
            end else if (bit_end) begin
                baud_cnt <= '0;
                if (frame_end) begin
                    bit_cnt <= '0;
                    state   <= next_state;
                    shift   <= next_state == IDLE ? '1 : {1'b1, next_byte, 1'b0};
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift   <= {1'b1, shift[9:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_remote_cmd_tx.sv
// tb_remote_cmd_tx: directed and randomized checks of remote_cmd_tx against a line-level model
module tb_remote_cmd_tx;
    localparam int B = 16;
`ifdef CMD_TX_CHKSUM_EN
    localparam int NF = 3;
`else
    localparam int NF = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = '0;
    logic        TX, busy, cmd_sent;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    remote_cmd_tx #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd),
        .TX(TX), .busy(busy), .cmd_sent(cmd_sent)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends c, records TX once per clock, then decodes the record by sampling mid-bit
    // against the expected byte sequence and the 10*B-clock frame timing.
    task automatic send(input logic [15:0] c, input int inj_at, input logic [15:0] inj_cmd,
                        input int rst_at);
        logic       tx_s[$];
        logic [7:0] eb[3];
        logic [7:0] got;
        int         done = -1;
        int         f = -1;
        int         base;
        cmd = c;
        snd_cmd = 1'b1;
        @(posedge clk);
        #1 snd_cmd = 1'b0;
        for (int i = 0; i < NF * 10 * B + 40 && done < 0; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_tx", TX, 1);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_sent", cmd_sent, 0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            snd_cmd = i == inj_at;
            if (i == inj_at) cmd = inj_cmd;
            tx_s.push_back(TX);
            if (i == 0) begin
                chk("accept_busy", busy, 1);
                chk("accept_sent_clr", cmd_sent, 0);
                chk("accept_tx_idle", TX, 1);
            end
            if (!busy) done = i;
        end
        snd_cmd = 1'b0;
        for (int i = 0; i < tx_s.size(); i++) if (f < 0 && tx_s[i] == 1'b0) f = i;
        chk("done_seen", 16'(done >= 0), 1);
        chk("start_latency", 16'(f), 1);
        chk("done_time", 16'(done - f), 16'(NF * 10 * B));
        chk("done_sent", cmd_sent, 1);
        chk("done_tx_idle", TX, 1);
        eb[0] = c[15:8];
        eb[1] = c[7:0];
        eb[2] = c[15:8] ^ c[7:0];
        for (int n = 0; n < NF; n++) begin
            base = f + 10 * n * B + B / 2;
            chk("start_bit", (base >= 0 && base < tx_s.size()) ? tx_s[base] : 1'bx, 0);
            for (int j = 0; j < 8; j++) begin
                base = f + (10 * n + 1 + j) * B + B / 2;
                got[j] = (base >= 0 && base < tx_s.size()) ? tx_s[base] : 1'bx;
            end
            chk("data_byte", got, eb[n]);
            base = f + (10 * n + 9) * B + B / 2;
            chk("stop_bit", (base >= 0 && base < tx_s.size()) ? tx_s[base] : 1'bx, 1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", TX, 1);
        chk("reset_busy", busy, 0);
        chk("reset_sent", cmd_sent, 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_tx", TX, 1);
        chk("idle_busy", busy, 0);
        chk("idle_sent", cmd_sent, 0);
        send(16'hA5C3, 100, 16'h1234, -1);
        send(16'h0001, -1, 16'h0000, -1);
        send(16'hFFFF, -1, 16'h0000, -1);
        send(16'(B * 37), -1, 16'h0000, 150);
        chk("post_rst_sent", cmd_sent, 0);
        @(negedge clk);
        send(16'h00FF, -1, 16'h0000, -1);
        for (int r = 0; r < 4; r++)
            send(16'($urandom), int'($urandom_range(5, 300)), 16'($urandom), -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
